// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: one integrate/leak/threshold update per
// in_valid timestep, with saturation, a zero floor and a refractory window.
module lif_neuron #(
  parameter int CNT_W     = 8,
  parameter int POT_W     = 16,
  parameter int WEIGHT    = 1,
  parameter int LEAK      = 1,
  parameter int THRESHOLD = 16,
  parameter int REFRAC    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] spk_cnt,
  output logic             out_valid,
  output logic             spike_out,
  output logic [POT_W-1:0] potential,
  output logic             refractory
);

  // Wide enough that potential + spk_cnt*WEIGHT can never wrap.
  localparam int ACC_W = POT_W + CNT_W + 33;
  localparam int RC_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic [ACC_W-1:0] WEIGHT_V = ACC_W'(WEIGHT);
  localparam logic [ACC_W-1:0] LEAK_V   = ACC_W'(LEAK);
  localparam logic [ACC_W-1:0] THR_V    = ACC_W'(THRESHOLD);
  localparam logic [ACC_W-1:0] MAX_V    = ACC_W'({POT_W{1'b1}});
  localparam logic [RC_W-1:0]  REFR_V   = RC_W'(REFRAC);
  localparam logic [RC_W-1:0]  ONE_V    = RC_W'(1);

  typedef enum logic {
    INTEG,
    REFR
  } state_e;

  state_e            state_q, state_d;
  logic [POT_W-1:0]  pot_q, pot_d;
  logic [RC_W-1:0]   cnt_q, cnt_d;
  logic              spike_q, spike_d;
  logic              ovalid_q, ovalid_d;
  logic              refr_q, refr_d;

  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  leaked;
  logic [ACC_W-1:0]  sat;
  logic              fire;

  always_comb begin
    sum    = ACC_W'(pot_q) + ACC_W'(spk_cnt) * WEIGHT_V;
    leaked = (sum > LEAK_V) ? sum - LEAK_V : '0;
    sat    = (leaked > MAX_V) ? MAX_V : leaked;
    fire   = (sat >= THR_V);
  end

  always_comb begin
    state_d  = state_q;
    pot_d    = pot_q;
    cnt_d    = cnt_q;
    spike_d  = 1'b0;
    ovalid_d = in_valid;
    if (in_valid) begin
      unique case (state_q)
        INTEG: begin
          if (fire) begin
            spike_d = 1'b1;
            pot_d   = '0;
            if (REFRAC > 0) begin
              state_d = REFR;
              cnt_d   = REFR_V;
            end
          end else begin
            pot_d = sat[POT_W-1:0];
          end
        end
        REFR: begin
          pot_d = '0;
          cnt_d = cnt_q - ONE_V;
          if (cnt_q == ONE_V) begin
            state_d = INTEG;
          end
        end
        default: begin
          state_d = INTEG;
        end
      endcase
    end
    refr_d = (state_d == REFR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INTEG;
      pot_q    <= '0;
      cnt_q    <= '0;
      spike_q  <= 1'b0;
      ovalid_q <= 1'b0;
      refr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pot_q    <= pot_d;
      cnt_q    <= cnt_d;
      spike_q  <= spike_d;
      ovalid_q <= ovalid_d;
      refr_q   <= refr_d;
    end
  end

  assign out_valid  = ovalid_q;
  assign spike_out  = spike_q;
  assign potential  = pot_q;
  assign refractory = refr_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Scoreboard bench: default neuron plus an 8-bit saturating variant,
// both driven by the same stimulus and checked against a timestep model.
module tb_lif_neuron;

  localparam int LEAK   = 1;
  localparam int REFRAC = 2;
  localparam int M_W    = 1;
  localparam int M_THR  = 16;
  localparam int M_MAX  = 65535;
  localparam int S_W    = 4;
  localparam int S_THR  = 255;
  localparam int S_MAX  = 255;

  typedef struct {
    int pot;
    int left;
  } mstate_t;

  typedef struct {
    bit spk;
    int pot;
    bit refr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  spk_cnt = '0;

  logic        m_ov, m_spk, m_refr;
  logic [15:0] m_pot;
  logic        s_ov, s_spk, s_refr;
  logic [7:0]  s_pot;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t    q_m[$];
  exp_t    q_s[$];
  mstate_t md_m = '{0, 0};
  mstate_t md_s = '{0, 0};

  lif_neuron u_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .spk_cnt(spk_cnt),
    .out_valid(m_ov), .spike_out(m_spk), .potential(m_pot),
    .refractory(m_refr)
  );

  lif_neuron #(
    .CNT_W(8), .POT_W(8), .WEIGHT(S_W), .LEAK(LEAK),
    .THRESHOLD(S_THR), .REFRAC(REFRAC)
  ) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .spk_cnt(spk_cnt),
    .out_valid(s_ov), .spike_out(s_spk), .potential(s_pot),
    .refractory(s_refr)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One timestep of the neuron: ignored steps left, else integrate/leak/fire.
  function automatic void mstep(inout mstate_t s, input int cnt,
                                input int w, input int maxv,
                                input int thr, output exp_t e);
    longint acc;
    e.spk = 1'b0;
    if (s.left > 0) begin
      s.left--;
      s.pot = 0;
    end else begin
      acc = longint'(s.pot) + longint'(cnt) * w;
      acc = (acc > LEAK) ? acc - LEAK : 0;
      if (acc > maxv) acc = maxv;
      if (acc >= thr) begin
        e.spk  = 1'b1;
        s.pot  = 0;
        s.left = REFRAC;
      end else begin
        s.pot = int'(acc);
      end
    end
    e.pot  = s.pot;
    e.refr = (s.left > 0);
  endfunction

  task automatic drive(int c);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    spk_cnt  = 8'(c);
    mstep(md_m, c, M_W, M_MAX, M_THR, e);
    q_m.push_back(e);
    mstep(md_s, c, S_W, S_MAX, S_THR, e);
    q_s.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    md_m     = '{0, 0};
    md_s     = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", m_ov, 0);
    chk("rst_spike", m_spk, 0);
    chk("rst_potential", m_pot, 0);
    chk("rst_refractory", m_refr, 0);
    chk("rst_sat_potential", s_pot, 0);
  endtask

  // Monitors: pop one expectation per presented output.
  always @(negedge clk) begin
    exp_t e;
    if (m_ov === 1'b1) begin
      if (q_m.size() == 0) begin
        chk("m_unexpected_valid", 1, 0);
      end else begin
        e = q_m.pop_front();
        chk("m_spike", m_spk, e.spk);
        chk("m_potential", m_pot, e.pot);
        chk("m_refractory", m_refr, e.refr);
      end
    end else begin
      chk("m_spike_idle", m_spk, 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (s_ov === 1'b1) begin
      if (q_s.size() == 0) begin
        chk("s_unexpected_valid", 1, 0);
      end else begin
        e = q_s.pop_front();
        chk("s_spike", s_spk, e.spk);
        chk("s_potential", s_pot, e.pot);
        chk("s_refractory", s_refr, e.refr);
      end
    end else begin
      chk("s_spike_idle", s_spk, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    do_reset();

    // integrate and fire: 4, 8, 12, then spike
    drive(5); idle(); @(negedge clk); chk("if_pot1", m_pot, 4);
    drive(5); idle(); @(negedge clk); chk("if_pot2", m_pot, 8);
    drive(5); idle(); @(negedge clk); chk("if_pot3", m_pot, 12);
    drive(5); idle(); @(negedge clk);
    chk("if_spike", m_spk, 1);
    chk("if_pot4", m_pot, 0);

    // refractory: two ignored steps, third fires
    drive(20); idle(); @(negedge clk);
    chk("refr1_flag", m_refr, 1);
    chk("refr1_spike", m_spk, 0);
    chk("refr1_pot", m_pot, 0);
    drive(20); idle(); @(negedge clk);
    chk("refr2_spike", m_spk, 0);
    chk("refr2_pot", m_pot, 0);
    drive(20); idle(); @(negedge clk);
    chk("refr3_spike", m_spk, 1);

    // leak floor and idle gaps
    do_reset();
    drive(0); idle(); @(negedge clk); chk("floor_pot", m_pot, 0);
    drive(9); idle(); @(negedge clk); chk("gap_pot_start", m_pot, 8);
    repeat (5) begin
      @(negedge clk);
      chk("gap_valid", m_ov, 0);
      chk("gap_pot", m_pot, 8);
    end

    // saturation on the 8-bit variant
    do_reset();
    drive(255); idle(); @(negedge clk);
    chk("sat_spike", s_spk, 1);
    chk("sat_pot", s_pot, 0);

    // reset in the middle of the refractory window
    do_reset();
    drive(20); idle(); @(negedge clk);
    chk("mid_refr_entered", m_refr, 1);
    do_reset();
    drive(3); idle(); @(negedge clk);
    chk("mid_refr_after", m_pot, 2);
    chk("mid_refr_flag", m_refr, 0);

    // random timesteps, including back-to-back strobes and resets
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else if (r < 70) begin
        if ($urandom_range(0, 3) == 0) drive($urandom_range(0, 255));
        else drive($urandom_range(0, 8));
      end else begin
        idle();
      end
    end

    idle();
    repeat (3) @(negedge clk);
    chk("m_queue_drained", q_m.size(), 0);
    chk("s_queue_drained", q_s.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
